seq_det_stream_ctrl: RTL and testbench
======================================

// Module: seq_det_stream_ctrl
// PURPOSE
//  Feeds parallel words into a serial pattern-matcher, one bit per clock, and keeps a running match count.
//  Sits between a word-wide producer (valid/ready) and the bit-serial sequence detection datapath.
//  Pattern and overlap mode are configurable per word.
//  Detector history persists across words, so matches can span word boundaries.
// PARAMETERS
//  DATA_W  8  width of each input word (bits serialised per accepted word)
//  PAT_W   4  pattern length in bits (2..DATA_W)
//  CNT_W   8  width of saturating hit counter
// PORTS
//  clk          in   1       rising-edge clock
//  arstn        in   1       asynchronous active-low reset
//  in_valid     in   1       producer has a word on in_data
//  in_ready     out  1       controller can accept a word (registered)
//  in_data      in   DATA_W  word to serialise
//  pattern      in   PAT_W   target pattern; pattern[PAT_W-1] is the oldest bit
//  overlap_mode in   1       1 = overlapping detection, 0 = non-overlapping
//  clear        in   1       synchronous clear of history, count and FSM
//  busy         out  1       serialisation in progress
//  hit          out  1       one-cycle pulse per pattern match
//  hit_count    out  CNT_W   saturating number of matches since reset/clear
//  done         out  1       one-cycle pulse after the last bit of a word
// BEHAVIOUR
//  Reset (arstn=0): state IDLE; in_ready=0, busy=0, hit=0, done=0, hit_count=0, window=0, win_fill=0.
//  First clk edge after arstn rises: in_ready goes to 1.
//  FSM states: IDLE, SHIFT, DONE.
//   IDLE : in_ready=1.
//          in_valid&in_ready at edge E0 -> capture in_data, pattern, overlap_mode; bit_cnt=DATA_W-1.
//          Same edge: in_ready->0, busy->1, go SHIFT.
//   SHIFT: each edge shifts the next bit into window[PAT_W-1:0] (MSB of word first).
//          win_fill saturates at PAT_W; bit_cnt decrements.
//          At the edge with bit_cnt==0 -> go DONE.
//   DONE : done=1 for exactly one cycle, busy=0; next edge -> IDLE with in_ready=1.
//  Match: new window == latched pattern and new win_fill==PAT_W.
//   -> hit=1 in the cycle after the consuming edge; hit_count+1 unless at all-ones (saturate, no wrap).
//   Non-overlap mode: win_fill resets to 0 on that edge, so the next match needs PAT_W fresh bits.
//   Overlap mode: window and win_fill are kept.
//  Latency: word accepted at E0, bits consumed at E1..E_DATA_W; done high in cycle after E_DATA_W.
//   Throughput: one word per DATA_W+2 cycles.
//  clear=1: highest priority after reset. Next edge: window, win_fill, hit_count=0; state IDLE; in_ready=1.
//   Aborts an in-flight word with no done and no hit.
//   in_valid during clear is not accepted (in_ready forced 0 in that cycle's decision).
//  pattern/overlap_mode changes while busy: ignored until the next accepted word.
//  arstn asserted mid-SHIFT: immediate return to reset values; the partial word is lost.
// CONFIGURATION
//  SEQ_DET_LSB_FIRST_EN defined  : words serialised LSB first (in_data[0] at E1).
//  SEQ_DET_LSB_FIRST_EN undefined: MSB first (in_data[DATA_W-1] at E1), the default.
//  Pattern orientation (pattern[PAT_W-1] oldest) is unchanged in both builds.
// STRUCTURE
//  seq_det_pkg: FSM state encodings (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10) and default widths.
//  Sub-module pattern_window_match: window shift register, win_fill counter, compare and overlap reset.
//   Inputs: bit_in, bit_en, pattern, overlap_mode, clear. Output: match.
//  Top level holds the FSM, word register, bit counter, hit counter and handshake.
// TESTING
//  1. pattern=4'b1101, overlap=1, word 8'b1101_1010 -> 2 hit pulses (after E4, E7); hit_count=2; done after E8.
//  2. Same word after clear, overlap=0 -> 1 hit (after E4); hit_count=1.
//  3. overlap=1, pattern=4'b1101, words 8'b0000_0110 then 8'b1000_0000 -> 1 hit on E1 of second word.
//  4. pattern=4'b1111, overlap=1, 40 words of 8'hFF -> hit_count stops at 8'hFF; no wrap to 0.
//  5. arstn low after 3 bits of a word -> all outputs 0 asynchronously; after release in_ready=1, hit_count=0.
//     clear during SHIFT -> IDLE next cycle, no done pulse.
//  6. LSB-first build (SEQ_DET_LSB_FIRST_EN), pattern=4'b1101, word 8'b0000_1011 -> 1 hit after E4.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared FSM encoding and default widths for the serial sequence detector slice.
package seq_det_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_PAT_W  = 4;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/seq_det_stream_ctrl_pattern_window_match.sv
// Bit-serial history window with fill tracking; flags a match on the bit that completes the pattern.
module pattern_window_match
    import seq_det_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             bit_in,
    input  logic             bit_en,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap_mode,
    input  logic             clear,
    output logic             match
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  window_reg;
    logic [PAT_W-1:0]  window_next;
    logic [FILL_W-1:0] fill_reg;
    logic [FILL_W-1:0] fill_next;

    // Oldest bit lives at the MSB so the window lines up directly with the pattern.
    assign window_next[0] = bit_in;
    generate
        for (genvar gi = 1; gi < PAT_W; gi++) begin : g_shift
            assign window_next[gi] = window_reg[gi-1];
        end
    endgenerate

    assign fill_next = (fill_reg == FILL_FULL) ? FILL_FULL : fill_reg + FILL_W'(1);
    assign match     = bit_en && (window_next == pattern) && (fill_next == FILL_FULL);

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            window_reg <= '0;
            fill_reg   <= '0;
        end else if (clear) begin
            window_reg <= '0;
            fill_reg   <= '0;
        end else if (bit_en) begin
            window_reg <= window_next;
            // Non-overlapping detection restarts the fill so the next hit needs fresh bits.
            fill_reg   <= (match && !overlap_mode) ? '0 : fill_next;
        end
    end

endmodule

// File: rtl/seq_det_stream_ctrl.sv
// Word-to-bit serialiser feeding the pattern window, with saturating hit counter.
// Build option SEQ_DET_LSB_FIRST_EN serialises each word LSB first (default MSB first).
module seq_det_stream_ctrl
    import seq_det_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int PAT_W  = DEF_PAT_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              arstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PAT_W-1:0]  pattern,
    input  logic              overlap_mode,
    input  logic              clear,
    output logic              busy,
    output logic              hit,
    output logic [CNT_W-1:0]  hit_count,
    output logic              done
);

    localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);

    state_t            state_reg;
    logic [DATA_W-1:0] word_reg;
    logic [BC_W-1:0]   bit_cnt_reg;
    logic [PAT_W-1:0]  pat_reg;
    logic              ovl_reg;
    logic              in_ready_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              hit_reg;
    logic [CNT_W-1:0]  hit_count_reg;

    logic bit_en;
    logic bit_in;
    logic match;

    assign bit_en = (state_reg == SHIFT) && !clear;

`ifdef SEQ_DET_LSB_FIRST_EN
    assign bit_in = word_reg[BC_LAST - bit_cnt_reg];
`else
    assign bit_in = word_reg[bit_cnt_reg];
`endif

    pattern_window_match #(
        .PAT_W(PAT_W)
    ) u_match (
        .clk         (clk),
        .arstn       (arstn),
        .bit_in      (bit_in),
        .bit_en      (bit_en),
        .pattern     (pat_reg),
        .overlap_mode(ovl_reg),
        .clear       (clear),
        .match       (match)
    );

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_reg     <= IDLE;
            word_reg      <= '0;
            bit_cnt_reg   <= '0;
            pat_reg       <= '0;
            ovl_reg       <= 1'b0;
            in_ready_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            hit_reg       <= 1'b0;
            hit_count_reg <= '0;
        end else if (clear) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            hit_reg       <= 1'b0;
            hit_count_reg <= '0;
        end else begin
            hit_reg  <= match;
            done_reg <= 1'b0;
            if (match && (hit_count_reg != '1)) begin
                hit_count_reg <= hit_count_reg + CNT_W'(1);
            end
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready_reg) begin
                        word_reg     <= in_data;
                        pat_reg      <= pattern;
                        ovl_reg      <= overlap_mode;
                        bit_cnt_reg  <= BC_LAST;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        state_reg    <= SHIFT;
                    end else begin
                        in_ready_reg <= 1'b1;
                    end
                end
                SHIFT: begin
                    bit_cnt_reg <= bit_cnt_reg - BC_W'(1);
                    if (bit_cnt_reg == '0) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    in_ready_reg <= 1'b1;
                    state_reg    <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign hit       = hit_reg;
    assign hit_count = hit_count_reg;

endmodule

// File: tb/tb_seq_det_stream_ctrl.sv
// Randomised and directed bench for seq_det_stream_ctrl against a bit-history reference model.
module tb_seq_det_stream_ctrl;

    localparam int DATA_W = 8;
    localparam int PAT_W  = 4;
    localparam int CNT_W  = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              arstn = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic [PAT_W-1:0]  pattern = '0;
    logic              overlap_mode = 1'b0;
    logic              clear = 1'b0;
    logic              in_ready;
    logic              busy;
    logic              hit;
    logic [CNT_W-1:0]  hit_count;
    logic              done;

    int total = 0;
    int bad   = 0;

    // Reference: every bit since the last clear, plus where the last non-overlap match ended.
    int hist[$];
    int last_reset;
    int model_cnt;

    seq_det_stream_ctrl #(
        .DATA_W(DATA_W),
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .arstn       (arstn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .pattern     (pattern),
        .overlap_mode(overlap_mode),
        .clear       (clear),
        .busy        (busy),
        .hit         (hit),
        .hit_count   (hit_count),
        .done        (done)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        hist.delete();
        last_reset = -1;
        model_cnt  = 0;
    endfunction

    function automatic bit model_bit(input bit b, input logic [PAT_W-1:0] pat, input bit ovl);
        int i;
        bit m;
        hist.push_back(int'(b));
        i = hist.size() - 1;
        m = 1'b0;
        if (i >= PAT_W - 1 && (i - PAT_W + 1) > last_reset) begin
            m = 1'b1;
            for (int j = 0; j < PAT_W; j++)
                if (hist[i-PAT_W+1+j] != int'(pat[PAT_W-1-j])) m = 1'b0;
        end
        if (m) begin
            if (!ovl) last_reset = i;
            if (model_cnt < CNT_MAX) model_cnt++;
        end
        return m;
    endfunction

    function automatic bit word_bit(input logic [DATA_W-1:0] d, input int k);
`ifdef SEQ_DET_LSB_FIRST_EN
        return d[k-1];
`else
        return d[DATA_W-k];
`endif
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_timeout in_ready=%b required=1", in_ready);
        end
    endtask

    // Sends one word and checks every cycle up to the return to IDLE.
    task automatic run_word(input logic [DATA_W-1:0] d, input logic [PAT_W-1:0] pat,
                            input bit ovl, input bit scramble);
        int hits = 0;
        bit exp_hit;
        wait_ready();
        in_valid = 1'b1;
        in_data = d;
        pattern = pat;
        overlap_mode = ovl;
        @(negedge clk);
        in_valid = 1'b0;
        if (scramble) begin
            in_data = DATA_W'($urandom);
            pattern = PAT_W'($urandom);
            overlap_mode = 1'($urandom);
        end
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL accept busy=%b in_ready=%b required busy=1 in_ready=0", busy, in_ready);
        end
        for (int k = 1; k <= DATA_W; k++) begin
            @(negedge clk);
            exp_hit = model_bit(word_bit(d, k), pat, ovl);
            if (exp_hit) hits++;
            total++;
            if (hit !== exp_hit) begin
                bad++;
                $display("FAIL hit bit=%0d got=%b required=%b", k, hit, exp_hit);
            end
            total++;
            if (hit_count !== CNT_W'(model_cnt)) begin
                bad++;
                $display("FAIL hit_count bit=%0d got=%0d required=%0d", k, hit_count, model_cnt);
            end
            total++;
            if (done !== (k == DATA_W) || busy !== (k != DATA_W)) begin
                bad++;
                $display("FAIL done_busy bit=%0d done=%b busy=%b required done=%b busy=%b",
                         k, done, busy, k == DATA_W, k != DATA_W);
            end
        end
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || done !== 1'b0 || hit !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_return in_ready=%b done=%b hit=%b busy=%b required 1 0 0 0",
                     in_ready, done, hit, busy);
        end
        $display("word data=%b pattern=%b overlap=%0d hits=%0d hit_count=%0d",
                 d, pat, ovl, hits, hit_count);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_clear();
        total++;
        if (in_ready !== 1'b1 || hit_count !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL clear in_ready=%b hit_count=%0d busy=%b required 1 0 0",
                     in_ready, hit_count, busy);
        end
    endtask

    task automatic test_reset();
        model_clear();
        #12;
        total++;
        if ({in_ready, busy, hit, done, hit_count} !== '0) begin
            bad++;
            $display("FAIL reset_values in_ready=%b busy=%b hit=%b done=%b hit_count=%0d required all 0",
                     in_ready, busy, hit, done, hit_count);
        end
        @(negedge clk);
        arstn = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_before_edge got=%b required=0", in_ready);
        end
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_edge got=%b required=1", in_ready);
        end
    endtask

    task automatic test_overlap();
        run_word(8'b1101_1010, 4'b1101, 1'b1, 1'b0);
        total++;
        if (hit_count !== 8'd2) begin
            bad++;
            $display("FAIL overlap_count got=%0d required=2", hit_count);
        end
    endtask

    task automatic test_nonoverlap();
        do_clear();
        run_word(8'b1101_1010, 4'b1101, 1'b0, 1'b0);
        total++;
        if (hit_count !== 8'd1) begin
            bad++;
            $display("FAIL nonoverlap_count got=%0d required=1", hit_count);
        end
    endtask

    task automatic test_boundary();
        do_clear();
        run_word(8'b0000_0110, 4'b1101, 1'b1, 1'b0);
        run_word(8'b1000_0000, 4'b1101, 1'b1, 1'b0);
        total++;
        if (hit_count !== 8'd1) begin
            bad++;
            $display("FAIL boundary_count got=%0d required=1", hit_count);
        end
    endtask

    task automatic test_saturation();
        do_clear();
        for (int w = 0; w < 40; w++) run_word(8'hFF, 4'b1111, 1'b1, 1'b0);
        total++;
        if (hit_count !== 8'hFF) begin
            bad++;
            $display("FAIL saturation got=%0d required=255", hit_count);
        end
    endtask

    task automatic test_async_reset();
        wait_ready();
        in_valid = 1'b1;
        in_data = 8'hA5;
        pattern = 4'b0101;
        overlap_mode = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        arstn = 1'b0;
        #1;
        total++;
        if ({in_ready, busy, hit, done, hit_count} !== '0) begin
            bad++;
            $display("FAIL async_reset in_ready=%b busy=%b hit=%b done=%b hit_count=%0d required all 0",
                     in_ready, busy, hit, done, hit_count);
        end
        @(negedge clk);
        arstn = 1'b1;
        model_clear();
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || hit_count !== '0) begin
            bad++;
            $display("FAIL async_release in_ready=%b hit_count=%0d required 1 0", in_ready, hit_count);
        end
    endtask

    task automatic test_clear_abort();
        int seen_done = 0;
        wait_ready();
        in_valid = 1'b1;
        in_data = 8'hFF;
        pattern = 4'b1111;
        overlap_mode = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_clear();
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || hit_count !== '0 || done !== 1'b0 || hit !== 1'b0) begin
            bad++;
            $display("FAIL clear_abort busy=%b in_ready=%b hit_count=%0d done=%b hit=%b required 0 1 0 0 0",
                     busy, in_ready, hit_count, done, hit);
        end
        repeat (10) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1 || hit === 1'b1) seen_done++;
        end
        total++;
        if (seen_done != 0) begin
            bad++;
            $display("FAIL clear_no_done activity_cycles=%0d required=0", seen_done);
        end
        // A word offered while clear is high must not be taken.
        in_valid = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        clear = 1'b0;
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL clear_blocks_valid busy=%b in_ready=%b required 0 1", busy, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        do_clear();
        for (int w = 0; w < 30; w++) begin
            logic [DATA_W-1:0] d;
            logic [PAT_W-1:0] p;
            d = DATA_W'($urandom);
            p = PAT_W'($urandom_range(0, 3));
            run_word(d, p, 1'($urandom), 1'b1);
        end
    endtask

`ifdef SEQ_DET_LSB_FIRST_EN
    task automatic test_lsb_first();
        do_clear();
        run_word(8'b0000_1011, 4'b1101, 1'b1, 1'b0);
        total++;
        if (hit_count !== 8'd1) begin
            bad++;
            $display("FAIL lsb_first_count got=%0d required=1", hit_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_boundary();
        test_saturation();
        test_async_reset();
        test_clear_abort();
        test_back_to_back();
`ifdef SEQ_DET_LSB_FIRST_EN
        test_lsb_first();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
